// File: rtl/dense_layer_sequencer.sv
// rtl/dense_layer_sequencer.sv - sequencer for one fully connected layer over a shared FPU
// Walks neurons and inputs, accumulating bias + sum(x*w) and writing the ReLU result.
module dense_layer_sequencer #(
    parameter int         IN_SIZE  = 784,
    parameter int         OUT_SIZE = 128,
    parameter int         FPU_LAT  = 4,
    parameter logic [1:0] RMODE    = 2'b11,
    localparam int IW = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1,
    localparam int WW = (IN_SIZE * OUT_SIZE > 1) ? $clog2(IN_SIZE * OUT_SIZE) : 1,
    localparam int OW = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [IW-1:0] in_addr,
    input  logic [31:0]   in_data,
    output logic [WW-1:0] w_addr,
    input  logic [31:0]   w_data,
    output logic [OW-1:0] b_addr,
    input  logic [31:0]   b_data,
    output logic [2:0]    fpu_op,
    output logic [1:0]    fpu_rmode,
    output logic [31:0]   fpu_opa,
    output logic [31:0]   fpu_opb,
    input  logic [31:0]   fpu_out,
    input  logic          fpu_exc,
    output logic [OW-1:0] out_addr,
    output logic [31:0]   out_data,
    output logic          out_we
);
    localparam int CW = (FPU_LAT > 1) ? $clog2(FPU_LAT) : 1;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_MUL = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE, S_BIAS_RD, S_BIAS_LD, S_RD, S_MUL, S_ADD, S_WRITE, S_DONE
    } state_t;

    state_t          state, state_d;
    logic [OW-1:0]   n;
    logic [IW-1:0]   i;
    logic [WW-1:0]   w_cnt;
    logic [CW-1:0]   cnt;
    logic [31:0]     acc;
    logic            lat_last, i_last, n_last, addr_step;

    assign lat_last  = (cnt == CW'(FPU_LAT - 1));
    assign i_last    = (i == IW'(IN_SIZE - 1));
    assign n_last    = (n == OW'(OUT_SIZE - 1));
    assign addr_step = (state == S_ADD) && lat_last;

    // Memories have one cycle of read latency, so the next input's address is
    // presented during the final ADD cycle and its data is ready in RD.
    assign in_addr   = (addr_step && !i_last) ? i + IW'(1) : i;
    assign w_addr    = addr_step ? w_cnt + WW'(1) : w_cnt;
    assign b_addr    = n;
    assign out_addr  = n;
    assign out_data  = acc[31] ? 32'h0 : acc;
    assign fpu_rmode = RMODE;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        busy    = (state != S_IDLE);
        done    = (state == S_DONE);
        out_we  = (state == S_WRITE);
        case (state)
            S_IDLE:    if (start) state_d = S_BIAS_RD;
            S_BIAS_RD: state_d = S_BIAS_LD;
            S_BIAS_LD: state_d = S_RD;
            S_RD:      state_d = S_MUL;
            S_MUL:     if (lat_last) state_d = S_ADD;
            S_ADD:     if (lat_last) state_d = i_last ? S_WRITE : S_RD;
            S_WRITE:   state_d = n_last ? S_DONE : S_BIAS_RD;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            n       <= '0;
            i       <= '0;
            w_cnt   <= '0;
            cnt     <= '0;
            acc     <= '0;
            err     <= 1'b0;
            fpu_op  <= OP_ADD;
            fpu_opa <= '0;
            fpu_opb <= '0;
        end else begin
            cnt <= ((state == S_MUL || state == S_ADD) && !lat_last) ? cnt + CW'(1) : '0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        n     <= '0;
                        i     <= '0;
                        w_cnt <= '0;
                        err   <= 1'b0;
                    end
                end
                S_BIAS_LD: acc <= b_data;
                S_RD: begin
                    fpu_opa <= in_data;
                    fpu_opb <= w_data;
                    fpu_op  <= OP_MUL;
                end
                S_MUL: begin
                    if (lat_last) begin
                        fpu_opa <= acc;
                        fpu_opb <= fpu_out;
                        fpu_op  <= OP_ADD;
                        err     <= err | fpu_exc;
                    end
                end
                S_ADD: begin
                    if (lat_last) begin
                        acc   <= fpu_out;
                        err   <= err | fpu_exc;
                        w_cnt <= w_cnt + WW'(1);
                        if (!i_last) i <= i + IW'(1);
                    end
                end
                S_WRITE: begin
                    i <= '0;
                    if (!n_last) n <= n + OW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule
